sa_phase_sequencer: RTL

//  Control sequencer for the self-attention (SA) datapath. Counts the 192-beat input stream and

---
 rtl/sa_pkg.sv | 62 ++++++
 rtl/sa_phase_sequencer_if.sv | 55 +++++
 rtl/sa_lat_pipe.sv | 44 ++++
 rtl/sa_phase_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the self-attention phase sequencer.
//   sa_op_e    : issue opcode presented to the SA datapath
//   sa_state_e : sequencer FSM state
//   SA_NBEATS / SA_WBEATS / SA_DIM : input stream length, weight beats, row width
//   sa_clamp_t : maps the raw T input onto an effective token count 1..8
//   sa_*_last  : last issue index of each phase for a given effective T
package sa_pkg;

  localparam int SA_NBEATS = 192;
  localparam int SA_WBEATS = 64;
  localparam int SA_DIM    = 8;

  typedef enum logic [2:0] {
    SA_OP_NOP    = 3'd0,
    SA_OP_PROJ_Q = 3'd1,
    SA_OP_PROJ_K = 3'd2,
    SA_OP_PROJ_V = 3'd3,
    SA_OP_SCORE  = 3'd4,
    SA_OP_OUT    = 3'd5
  } sa_op_e;

  typedef enum logic [2:0] {
    SA_IDLE  = 3'd0,
    SA_LOAD  = 3'd1,
    SA_PROJ  = 3'd2,
    SA_WAIT1 = 3'd3,
    SA_SCORE = 3'd4,
    SA_WAIT2 = 3'd5,
    SA_OUT   = 3'd6,
    SA_DRAIN = 3'd7
  } sa_state_e;

  function automatic logic [3:0] sa_clamp_t(input logic [3:0] t);
    logic [3:0] r;
    if (t == 4'd0)      r = 4'd1;
    else if (t > 4'd8)  r = 4'd8;
    else                r = t;
    return r;
  endfunction

  // 24*t - 1 : three projections of t rows by 8 columns
  function automatic logic [7:0] sa_proj_last(input logic [3:0] t);
    logic [7:0] x;
    x = {4'b0000, t};
    return (x << 4) + (x << 3) - 8'd1;
  endfunction

  // t*t - 1
  function automatic logic [7:0] sa_score_last(input logic [3:0] t);
    logic [7:0] x;
    x = {4'b0000, t};
    return (x * x) - 8'd1;
  endfunction

  // 8*t - 1
  function automatic logic [7:0] sa_out_last(input logic [3:0] t);
    logic [7:0] x;
    x = {4'b0000, t};
    return (x << 3) - 8'd1;
  endfunction

endpackage

// File: rtl/sa_phase_sequencer_if.sv
// sa_phase_sequencer_if: bundle between the SA sequencer and its environment.
//   inputs to sequencer : in_valid, T, cg_en
//   load strobes        : ld_x_we/ld_x_addr, ld_w_we/ld_w_addr
//   issue               : iss_op, iss_i, iss_j
//   clock gating        : sleep_proj, sleep_score, sleep_out
//   results / status    : out_valid, out_last, t_eff, ovl_err
//   perf_cycles         : present only when SA_SEQ_PERF_CNT_EN is defined
// modport slave is the sequencer side, master the stimulus/host side.
interface sa_phase_sequencer_if;
  import sa_pkg::*;

  logic        in_valid;
  logic [3:0]  T;
  logic        cg_en;
  logic        ld_x_we;
  logic [5:0]  ld_x_addr;
  logic        ld_w_we;
  logic [5:0]  ld_w_addr;
  sa_op_e      iss_op;
  logic [2:0]  iss_i;
  logic [2:0]  iss_j;
  logic        sleep_proj;
  logic        sleep_score;
  logic        sleep_out;
  logic        out_valid;
  logic        out_last;
  logic [3:0]  t_eff;
  logic        ovl_err;
`ifdef SA_SEQ_PERF_CNT_EN
  logic [15:0] perf_cycles;
`endif

  modport slave (
`ifdef SA_SEQ_PERF_CNT_EN
    output perf_cycles,
`endif
    input  in_valid, T, cg_en,
    output ld_x_we, ld_x_addr, ld_w_we, ld_w_addr,
    output iss_op, iss_i, iss_j,
    output sleep_proj, sleep_score, sleep_out,
    output out_valid, out_last, t_eff, ovl_err
  );

  modport master (
`ifdef SA_SEQ_PERF_CNT_EN
    input  perf_cycles,
`endif
    output in_valid, T, cg_en,
    input  ld_x_we, ld_x_addr, ld_w_we, ld_w_addr,
    input  iss_op, iss_i, iss_j,
    input  sleep_proj, sleep_score, sleep_out,
    input  out_valid, out_last, t_eff, ovl_err
  );

endinterface

// File: rtl/sa_lat_pipe.sv
// sa_lat_pipe: DEPTH-stage shift register that delays the OUT-issue marker
// and its last flag by the datapath latency, producing out_valid/out_last.
//   clk, rst            : clock, synchronous active-high reset
//   valid_in, last_in   : OUT issue present this cycle / final OUT issue
//   valid_out, last_out : the same, DEPTH cycles later
module sa_lat_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    valid_d[0] = valid_in;
    last_d[0]  = last_in;
    for (int s = 1; s < DEPTH; s++) begin
      valid_d[s] = valid_q[s-1];
      last_d[s]  = last_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign last_out  = last_q[DEPTH-1];

endmodule

// File: rtl/sa_phase_sequencer.sv
// sa_phase_sequencer: control sequencer for the self-attention datapath.
// Counts the 192-beat input stream into X/W load strobes, then issues one
// dot-product op per cycle through PROJ(Q,K,V) -> SCORE -> OUT, with DP_LAT
// bubbles between phases, and times out_valid/out_last against DP_LAT.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sa_phase_sequencer_if.slave (all data/control ports)
//   DP_LAT   : issue-to-result latency of the datapath, 1..7
// Optional: define SA_SEQ_PERF_CNT_EN to add bus.perf_cycles, the number of
// cycles from the accepting beat to out_last inclusive (saturating).
//
// state    | meaning
// IDLE     | waiting for first beat
// LOAD     | counting input beats 1..191
// PROJ     | Q, K, V projection issues
// WAIT1    | DP_LAT bubble before SCORE
// SCORE    | Q.K^T issues
// WAIT2    | DP_LAT bubble before OUT
// OUT      | S.V issues
// DRAIN    | DP_LAT cycles for last results to emerge
module sa_phase_sequencer
  import sa_pkg::*;
#(
  parameter int DP_LAT = 3
) (
  input logic clk,
  input logic rst,
  sa_phase_sequencer_if.slave bus
);

  localparam logic [7:0] B_LAST   = 8'(SA_NBEATS - 1);
  localparam logic [7:0] LAT_LAST = 8'(DP_LAT - 1);
  localparam logic [2:0] COL_LAST = 3'(SA_DIM - 1);

  sa_state_e  state_q, state_d;
  logic [7:0] b_q, b_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] i_q, i_d;
  logic [2:0] j_q, j_d;
  logic [1:0] pop_q, pop_d;
  logic [3:0] t_eff_q, t_eff_d;

  logic       ld_x_we_q, ld_x_we_d;
  logic [5:0] ld_x_addr_q, ld_x_addr_d;
  logic       ld_w_we_q, ld_w_we_d;
  logic [5:0] ld_w_addr_q, ld_w_addr_d;
  sa_op_e     iss_op_q, iss_op_d;
  logic [2:0] iss_i_q, iss_i_d;
  logic [2:0] iss_j_q, iss_j_d;
  logic       sleep_proj_q, sleep_proj_d;
  logic       sleep_score_q, sleep_score_d;
  logic       sleep_out_q, sleep_out_d;
  logic       ovl_err_q, ovl_err_d;

  logic       accept;
  logic [2:0] t_last;
  logic [7:0] proj_last, score_last, out_last_idx;
  logic       pipe_valid_in, pipe_last_in;
  logic       out_valid_w, out_last_w;

  assign accept       = bus.in_valid & ((state_q == SA_IDLE) | (state_q == SA_LOAD));
  assign t_last       = 3'(t_eff_q - 4'd1);
  assign proj_last    = sa_proj_last(t_eff_q);
  assign score_last   = sa_score_last(t_eff_q);
  assign out_last_idx = sa_out_last(t_eff_q);

  // next-state and counters
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    pop_d   = pop_q;
    t_eff_d = t_eff_q;
    case (state_q)
      SA_IDLE: begin
        if (bus.in_valid) begin
          t_eff_d = sa_clamp_t(bus.T);
          b_d     = 8'd1;
          state_d = SA_LOAD;
        end
      end
      SA_LOAD: begin
        if (bus.in_valid) begin
          if (b_q == B_LAST) begin
            b_d     = '0;
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
            pop_d   = '0;
            state_d = SA_PROJ;
          end else begin
            b_d = b_q + 8'd1;
          end
        end
      end
      SA_PROJ: begin
        cnt_d = cnt_q + 8'd1;
        if (j_q == COL_LAST) begin
          j_d = '0;
          if (i_q == t_last) begin
            i_d   = '0;
            pop_d = pop_q + 2'd1;
          end else begin
            i_d = i_q + 3'd1;
          end
        end else begin
          j_d = j_q + 3'd1;
        end
        if (cnt_q == proj_last) begin
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          pop_d   = '0;
          state_d = SA_WAIT1;
        end
      end
      SA_WAIT1: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = SA_SCORE;
        end
      end
      SA_SCORE: begin
        cnt_d = cnt_q + 8'd1;
        // score matrix is t x t, so the column wraps at t_eff
        if (j_q == t_last) begin
          j_d = '0;
          i_d = i_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
        if (cnt_q == score_last) begin
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = SA_WAIT2;
        end
      end
      SA_WAIT2: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = SA_OUT;
        end
      end
      SA_OUT: begin
        cnt_d = cnt_q + 8'd1;
        if (j_q == COL_LAST) begin
          j_d = '0;
          i_d = i_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
        if (cnt_q == out_last_idx) begin
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = SA_DRAIN;
        end
      end
      SA_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = SA_IDLE;
        end
      end
      default: state_d = SA_IDLE;
    endcase
  end

  // Outputs are computed from next-state values and registered, so the
  // issue seen in a cycle always matches the state held in that cycle.
  always_comb begin
    iss_op_d = SA_OP_NOP;
    iss_i_d  = '0;
    iss_j_d  = '0;
    case (state_d)
      SA_PROJ: begin
        iss_op_d = sa_op_e'(3'(pop_d) + 3'd1);
        iss_i_d  = i_d;
        iss_j_d  = j_d;
      end
      SA_SCORE: begin
        iss_op_d = SA_OP_SCORE;
        iss_i_d  = i_d;
        iss_j_d  = j_d;
      end
      SA_OUT: begin
        iss_op_d = SA_OP_OUT;
        iss_i_d  = i_d;
        iss_j_d  = j_d;
      end
      default: ;
    endcase

    // t_eff_d is already the latched value on beat 0, and b=0 always passes
    ld_x_we_d   = accept & (b_q < {1'b0, t_eff_d, 3'b000});
    ld_x_addr_d = b_q[5:0];
    ld_w_we_d   = accept & (b_q < 8'(SA_WBEATS));
    ld_w_addr_d = b_q[5:0];

    // projection wakes while the last beat is awaited, one cycle ahead of PROJ
    sleep_proj_d  = bus.cg_en & ~((state_d == SA_PROJ) |
                                  ((state_d == SA_LOAD) & (b_d == B_LAST)));
    sleep_score_d = bus.cg_en & (state_d != SA_SCORE);
    sleep_out_d   = bus.cg_en & (state_d != SA_OUT);

    ovl_err_d = bus.in_valid & ~((state_q == SA_IDLE) | (state_q == SA_LOAD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SA_IDLE;
      b_q           <= '0;
      cnt_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      pop_q         <= '0;
      t_eff_q       <= '0;
      ld_x_we_q     <= 1'b0;
      ld_x_addr_q   <= '0;
      ld_w_we_q     <= 1'b0;
      ld_w_addr_q   <= '0;
      iss_op_q      <= SA_OP_NOP;
      iss_i_q       <= '0;
      iss_j_q       <= '0;
      sleep_proj_q  <= 1'b0;
      sleep_score_q <= 1'b0;
      sleep_out_q   <= 1'b0;
      ovl_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      i_q           <= i_d;
      j_q           <= j_d;
      pop_q         <= pop_d;
      t_eff_q       <= t_eff_d;
      ld_x_we_q     <= ld_x_we_d;
      ld_x_addr_q   <= ld_x_addr_d;
      ld_w_we_q     <= ld_w_we_d;
      ld_w_addr_q   <= ld_w_addr_d;
      iss_op_q      <= iss_op_d;
      iss_i_q       <= iss_i_d;
      iss_j_q       <= iss_j_d;
      sleep_proj_q  <= sleep_proj_d;
      sleep_score_q <= sleep_score_d;
      sleep_out_q   <= sleep_out_d;
      ovl_err_q     <= ovl_err_d;
    end
  end

  // state_q == OUT in exactly the cycles iss_op shows an OUT issue
  assign pipe_valid_in = (state_q == SA_OUT);
  assign pipe_last_in  = (state_q == SA_OUT) & (cnt_q == out_last_idx);

  sa_lat_pipe #(.DEPTH(DP_LAT)) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (pipe_valid_in),
    .last_in   (pipe_last_in),
    .valid_out (out_valid_w),
    .last_out  (out_last_w)
  );

`ifdef SA_SEQ_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == SA_IDLE) & bus.in_valid) begin
      perf_d = 16'd1;
    end else if ((state_q != SA_IDLE) & (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`endif

  assign bus.ld_x_we     = ld_x_we_q;
  assign bus.ld_x_addr   = ld_x_addr_q;
  assign bus.ld_w_we     = ld_w_we_q;
  assign bus.ld_w_addr   = ld_w_addr_q;
  assign bus.iss_op      = iss_op_q;
  assign bus.iss_i       = iss_i_q;
  assign bus.iss_j       = iss_j_q;
  assign bus.sleep_proj  = sleep_proj_q;
  assign bus.sleep_score = sleep_score_q;
  assign bus.sleep_out   = sleep_out_q;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_last    = out_last_w;
  assign bus.t_eff       = t_eff_q;
  assign bus.ovl_err     = ovl_err_q;

endmodule
